// File: rtl/load_align_unit.sv
// load_align_unit: gathers a 32-bit load word from a BUS_W-wide memory read
// bus, then selects, extends or merges (LWL/LWR) it for writeback. Misaligned
// lh/lhu/lw raise out_exc when EXC_EN=1. The result is held on a registered
// valid/ready output.
//
// Handshake rules for both interfaces:
// - A request transfers on a rising edge where req_valid=1 and req_ready=1.
// - A result transfers on a rising edge where out_valid=1 and out_ready=1.
// - While out_valid=1, out_data and out_exc do not change.
// - flush wins over every other input in the same cycle.
//
// BUS_W must be 8, 16 or 32.
module load_align_unit #(
  parameter int BUS_W  = 32,
  parameter bit EXC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_op,
  input  logic [1:0]       req_addr,
  input  logic [31:0]      req_rt,
  input  logic             mem_rvalid,
  input  logic [BUS_W-1:0] mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_exc,
  output logic [1:0]       dbg_state
);

  localparam int BEATS = 32 / BUS_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [31:0]      word_buf;
  logic [31:0]      word_next;
  logic [5:0]       op_q;
  logic [1:0]       addr_q;
  logic [31:0]      rt_q;
  logic             is_half;
  logic             misaligned;

  assign req_ready = (state == S_IDLE);
  assign dbg_state = state;

  // Misalignment is only judged on the incoming request; LWL/LWR and
  // unknown opcodes never fault.
  assign is_half    = (req_op == OP_LH) || (req_op == OP_LHU);
  assign misaligned = EXC_EN && ((is_half && req_addr[0]) ||
                                 ((req_op == OP_LW) && (req_addr != 2'b00)));

  // Word buffer with the current beat dropped into its slot.
  always_comb begin
    word_next = word_buf;
    word_next[int'(beat_cnt) * BUS_W +: BUS_W] = mem_rdata;
  end

  // Byte/half selection, extension and LWL/LWR merge of an assembled word.
  // Halves are chosen by a[1] alone and lw ignores a, so the address masking
  // needed when EXC_EN=0 falls out naturally.
  function automatic logic [31:0] align_word(input logic [5:0]  op,
                                             input logic [1:0]  a,
                                             input logic [31:0] rt,
                                             input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    r = w;
    case (op)
      OP_LB:  r = {{24{b[7]}}, b};
      OP_LBU: r = {24'h000000, b};
      OP_LH:  r = {{16{h[15]}}, h};
      OP_LHU: r = {16'h0000, h};
      OP_LWL: begin
        case (a)
          2'd0:    r = {w[7:0], rt[23:0]};
          2'd1:    r = {w[15:0], rt[15:0]};
          2'd2:    r = {w[23:0], rt[7:0]};
          default: r = w;
        endcase
      end
      OP_LWR: begin
        case (a)
          2'd0:    r = w;
          2'd1:    r = {rt[31:24], w[31:8]};
          2'd2:    r = {rt[31:16], w[31:16]};
          default: r = {rt[31:8], w[31:24]};
        endcase
      end
      default: r = w;
    endcase
    return r;
  endfunction

  // Control FSM: accept, collect beats, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      word_buf  <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      rt_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_exc   <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      word_buf  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            rt_q   <= req_rt;
            if (misaligned) begin
              out_valid <= 1'b1;
              out_exc   <= 1'b1;
              out_data  <= '0;
              state     <= S_DONE;
            end else begin
              beat_cnt <= '0;
              word_buf <= '0;
              state    <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (mem_rvalid) begin
            word_buf <= word_next;
            if (beat_cnt == LAST_BEAT) begin
              out_data  <= align_word(op_q, addr_q, rt_q, word_next);
              out_exc   <= 1'b0;
              out_valid <= 1'b1;
              beat_cnt  <= '0;
              state     <= S_DONE;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
